// File: rtl/idma_byte_lane_buffer_pkg.sv
// -----------------------------------------------------------------------------
// idma_byte_lane_buffer_pkg
//   Shared constants and helpers for the iDMA byte-lane buffer.
//   - ByteWidth : width of one byte lane.
//   - ptr_width : width of a lane pointer for a given depth (at least 1 bit).
//   - next_ptr  : pointer increment with wrap at depth-1. It uses an explicit
//                 compare rather than modulo arithmetic, so any depth works,
//                 including depths that are not a power of two.
// -----------------------------------------------------------------------------
package idma_byte_lane_buffer_pkg;

    localparam int unsigned ByteWidth = 8;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/idma_byte_lane_buffer_lane_fifo.sv
// -----------------------------------------------------------------------------
// idma_lane_fifo
//   One byte lane of the iDMA byte-lane buffer: a small FIFO with its own
//   valid/ready on each side.
//
//   Ports
//     clk_i, rst_ni : clock and asynchronous active-low reset
//     clear_i       : synchronous flush of pointers and count
//     in_data_i     : byte from the producer
//     in_valid_i    : push request
//     in_ready_o    : space available
//     out_data_o    : head byte
//     out_valid_o   : data available
//     out_ready_i   : pop request
//     empty_o       : lane holds no stored byte (registered state only)
//
//   Optional feature: IDMA_BUFFER_FALLTHROUGH_EN enables a same-cycle bypass
//   when the lane is empty.
// -----------------------------------------------------------------------------
module idma_lane_fifo
    import idma_byte_lane_buffer_pkg::*;
#(
    parameter int unsigned BufferDepth = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic [ByteWidth-1:0] in_data_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic [ByteWidth-1:0] out_data_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 empty_o
);

    localparam int unsigned PtrW = ptr_width(BufferDepth);
    localparam int unsigned CntW = $clog2(BufferDepth + 1);

    logic [ByteWidth-1:0] mem_q [BufferDepth];
    logic [PtrW-1:0]      wr_ptr_q;
    logic [PtrW-1:0]      rd_ptr_q;
    logic [CntW-1:0]      count_q;

    logic stored_valid;
    logic bypass;
    logic write_en;
    logic read_en;

    assign stored_valid = (count_q != '0);
    // Depends only on the count, so the consumer never reaches the producer
    // combinationally; a full lane that pops sees ready rise one cycle later.
    assign in_ready_o   = (count_q != CntW'(BufferDepth));
    assign empty_o      = ~stored_valid;

`ifdef IDMA_BUFFER_FALLTHROUGH_EN
    // An empty lane presents the incoming byte directly. If it is consumed in
    // the same cycle it never touches storage.
    assign out_valid_o = stored_valid | in_valid_i;
    assign out_data_o  = stored_valid ? mem_q[rd_ptr_q] : in_data_i;
    assign bypass      = ~stored_valid & in_valid_i & out_ready_i;
`else
    assign out_valid_o = stored_valid;
    assign out_data_o  = mem_q[rd_ptr_q];
    assign bypass      = 1'b0;
`endif

    assign write_en = in_valid_i & in_ready_o & ~bypass;
    assign read_en  = stored_valid & out_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(BufferDepth); i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear_i) begin
            // Storage is left as is; the reset pointers make it unreachable.
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (write_en) begin
                mem_q[wr_ptr_q] <= in_data_i;
                wr_ptr_q        <= PtrW'(next_ptr(32'(wr_ptr_q), BufferDepth));
            end
            if (read_en) begin
                rd_ptr_q <= PtrW'(next_ptr(32'(rd_ptr_q), BufferDepth));
            end
            if (write_en && !read_en) begin
                count_q <= count_q + CntW'(1);
            end else if (read_en && !write_en) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

endmodule

// File: rtl/idma_byte_lane_buffer.sv
// -----------------------------------------------------------------------------
// idma_byte_lane_buffer
//   Per-byte-lane elastic buffer between the iDMA read task and the OBI write
//   task. Each byte lane is an independent FIFO, so bytes pushed at the read
//   alignment can be popped at the write alignment.
//
//   Ports
//     clk_i, rst_ni : clock and asynchronous active-low reset
//     clear_i       : synchronous flush of all lanes (abort / poison)
//     in_data_i     : StrbWidth bytes from the read task
//     in_valid_i    : per-lane push request
//     in_ready_o    : per-lane space available
//     out_data_o    : head byte of every lane
//     out_valid_o   : per-lane data available
//     out_ready_i   : per-lane pop (write task byte-enable mask)
//     empty_o       : all lanes empty (registered state only)
//
//   Optional feature: define IDMA_BUFFER_FALLTHROUGH_EN for same-cycle bypass
//   on empty lanes; undefined gives a strict one-cycle latency.
// -----------------------------------------------------------------------------
module idma_byte_lane_buffer
    import idma_byte_lane_buffer_pkg::*;
#(
    parameter int unsigned BufferDepth = 3,
    parameter int unsigned StrbWidth   = 16,
    parameter type         byte_t      = logic [7:0],
    parameter type         strb_t      = logic [StrbWidth-1:0]
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           clear_i,
    input  logic [StrbWidth*ByteWidth-1:0] in_data_i,
    input  logic [StrbWidth-1:0]           in_valid_i,
    output logic [StrbWidth-1:0]           in_ready_o,
    output logic [StrbWidth*ByteWidth-1:0] out_data_o,
    output logic [StrbWidth-1:0]           out_valid_o,
    input  logic [StrbWidth-1:0]           out_ready_i,
    output logic                           empty_o
);

    if (BufferDepth < 1) begin : g_chk_depth
        $error("BufferDepth must be at least 1");
    end
    if ($bits(byte_t) != 8) begin : g_chk_byte
        $error("byte_t must be 8 bits wide");
    end
    if ($bits(strb_t) != StrbWidth) begin : g_chk_strb
        $error("strb_t must be StrbWidth bits wide");
    end

    logic [StrbWidth-1:0] lane_empty;

    for (genvar i = 0; i < StrbWidth; i++) begin : g_lane
        idma_lane_fifo #(
            .BufferDepth (BufferDepth)
        ) i_lane_fifo (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .clear_i     (clear_i),
            .in_data_i   (in_data_i[i*ByteWidth +: ByteWidth]),
            .in_valid_i  (in_valid_i[i]),
            .in_ready_o  (in_ready_o[i]),
            .out_data_o  (out_data_o[i*ByteWidth +: ByteWidth]),
            .out_valid_o (out_valid_o[i]),
            .out_ready_i (out_ready_i[i]),
            .empty_o     (lane_empty[i])
        );
    end

    assign empty_o = &lane_empty;

endmodule

// File: tb/tb_idma_byte_lane_buffer.sv
// -----------------------------------------------------------------------------
// tb_idma_byte_lane_buffer
//   Directed bench for idma_byte_lane_buffer (BufferDepth=3, StrbWidth=16).
// -----------------------------------------------------------------------------
module tb_idma_byte_lane_buffer;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         clear_i;
    logic [127:0] in_data_i;
    logic [15:0]  in_valid_i;
    logic [15:0]  in_ready_o;
    logic [127:0] out_data_o;
    logic [15:0]  out_valid_o;
    logic [15:0]  out_ready_i;
    logic         empty_o;

    int n_checks = 0;
    int n_fail   = 0;

    idma_byte_lane_buffer #(
        .BufferDepth (3),
        .StrbWidth   (16)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .in_data_i   (in_data_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .empty_o     (empty_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [7:0] lane_byte(input logic [127:0] bus, input int lane);
        return bus[lane*8 +: 8];
    endfunction

    logic [127:0] pattern;
    logic [7:0]   q[$];
    logic [7:0]   b;

    initial begin
        rst_ni      = 1'b0;
        clear_i     = 1'b0;
        in_data_i   = '0;
        in_valid_i  = '0;
        out_ready_i = '0;
        #1;
        check_eq("rst_in_ready",  128'(in_ready_o),  128'hFFFF);
        check_eq("rst_out_valid", 128'(out_valid_o), 128'h0);
        check_eq("rst_empty",     128'(empty_o),     128'h1);
        check_eq("rst_out_data",  out_data_o,        128'h0);
        tick();
        tick();
        rst_ni = 1'b1;
        tick();

        // ---- fill / drain lane 0, depth 3 ----
        in_valid_i = 16'h0001;
        in_data_i = '0; in_data_i[7:0] = 8'hA1;
        tick();
        check_eq("fill_lat1_valid", 128'(out_valid_o[0]), 128'h1);
        check_eq("fill_lat1_data", 128'(lane_byte(out_data_o, 0)), 128'hA1);
        in_data_i[7:0] = 8'hA2;
        tick();
        in_data_i[7:0] = 8'hA3;
        tick();
        check_eq("fill_full_ready", 128'(in_ready_o[0]), 128'h0);
        // push on a full lane is ignored; lane 3 is independent
        in_valid_i = 16'h0009;
        in_data_i[7:0] = 8'hFF;
        in_data_i[31:24] = 8'h33;
        tick();
        in_valid_i = '0;
        check_eq("full_head_kept", 128'(lane_byte(out_data_o, 0)), 128'hA1);
        check_eq("lane3_valid", 128'(out_valid_o[3]), 128'h1);
        check_eq("lane3_data", 128'(lane_byte(out_data_o, 3)), 128'h33);
        out_ready_i = 16'h0001;
        #1;
        check_eq("full_pop_ready_low", 128'(in_ready_o[0]), 128'h0);
        tick();
        check_eq("after_pop_ready", 128'(in_ready_o[0]), 128'h1);
        check_eq("drain_a2", 128'(lane_byte(out_data_o, 0)), 128'hA2);
        tick();
        check_eq("drain_a3", 128'(lane_byte(out_data_o, 0)), 128'hA3);
        tick();
        check_eq("drain_empty_lane0", 128'(out_valid_o[0]), 128'h0);
        check_eq("not_empty_lane3", 128'(empty_o), 128'h0);
        out_ready_i = 16'h0008;
        tick();
        out_ready_i = '0;
        check_eq("all_empty", 128'(empty_o), 128'h1);

        // ---- realignment: upper lanes first, lower lanes next cycle ----
        for (int i = 0; i < 16; i++) pattern[i*8 +: 8] = 8'(8'h40 + i * 7);
        in_data_i  = pattern;
        in_valid_i = 16'hFFF0;
        tick();
        in_valid_i = 16'h000F;
        tick();
        in_valid_i = '0;
        out_ready_i = 16'hFFFF;
        #1;
        check_eq("realign_valid", 128'(out_valid_o), 128'hFFFF);
        check_eq("realign_data", out_data_o, pattern);
        tick();
        out_ready_i = '0;
        check_eq("realign_drained", 128'(out_valid_o), 128'h0);
        check_eq("realign_empty", 128'(empty_o), 128'h1);

        // ---- sustained push+pop on lane 1, pointers wrap repeatedly ----
        q.delete();
        in_valid_i = 16'h0002;
        for (int k = 0; k < 2; k++) begin
            b = 8'($urandom_range(0, 255));
            in_data_i = '0; in_data_i[15:8] = b;
            q.push_back(b);
            tick();
        end
        out_ready_i = 16'h0002;
        for (int k = 0; k < 20; k++) begin
            b = 8'($urandom_range(0, 255));
            in_data_i[15:8] = b;
            #1;
            check_eq($sformatf("stream_%0d", k), 128'(lane_byte(out_data_o, 1)), 128'(q[0]));
            void'(q.pop_front());
            q.push_back(b);
            tick();
        end
        in_valid_i = '0;
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("stream_drain_%0d", k), 128'(lane_byte(out_data_o, 1)), 128'(q[0]));
            void'(q.pop_front());
            tick();
        end
        out_ready_i = '0;
        check_eq("stream_done", 128'(out_valid_o[1]), 128'h0);

        // ---- clear has priority over push and pop on lane 7 ----
        in_valid_i = 16'h0080;
        in_data_i = '0; in_data_i[63:56] = 8'h11;
        tick();
        clear_i = 1'b1;
        in_data_i[63:56] = 8'h22;
        out_ready_i = 16'h0080;
        tick();
        clear_i = 1'b0;
        in_valid_i = '0;
        out_ready_i = '0;
        check_eq("clear_valid", 128'(out_valid_o), 128'h0);
        check_eq("clear_empty", 128'(empty_o), 128'h1);
        in_valid_i = 16'h0080;
        in_data_i[63:56] = 8'h5C;
        tick();
        in_valid_i = '0;
        check_eq("clear_fresh_data", 128'(lane_byte(out_data_o, 7)), 128'h5C);
        out_ready_i = 16'h0080;
        tick();
        out_ready_i = '0;

        // ---- fall-through behaviour on lane 2 ----
        in_valid_i = 16'h0004;
        in_data_i = '0; in_data_i[23:16] = 8'h3E;
        out_ready_i = 16'h0004;
        #1;
`ifdef IDMA_BUFFER_FALLTHROUGH_EN
        check_eq("ft_same_valid", 128'(out_valid_o[2]), 128'h1);
        check_eq("ft_same_data", 128'(lane_byte(out_data_o, 2)), 128'h3E);
        check_eq("ft_empty_reg", 128'(empty_o), 128'h1);
        tick();
        in_valid_i = '0;
        out_ready_i = '0;
        check_eq("ft_bypassed", 128'(out_valid_o[2]), 128'h0);
        check_eq("ft_still_empty", 128'(empty_o), 128'h1);
`else
        check_eq("noft_same_valid", 128'(out_valid_o[2]), 128'h0);
        tick();
        in_valid_i = '0;
        check_eq("noft_next_valid", 128'(out_valid_o[2]), 128'h1);
        check_eq("noft_next_data", 128'(lane_byte(out_data_o, 2)), 128'h3E);
        tick();
        out_ready_i = '0;
        check_eq("noft_popped", 128'(empty_o), 128'h1);
`endif

        // ---- asynchronous reset mid-stream ----
        in_data_i  = pattern;
        in_valid_i = 16'hFFFF;
        tick();
        tick();
        in_valid_i = '0;
        check_eq("pre_rst_valid", 128'(out_valid_o), 128'hFFFF);
        #2;
        rst_ni = 1'b0;
        #1;
        check_eq("mid_rst_in_ready",  128'(in_ready_o),  128'hFFFF);
        check_eq("mid_rst_out_valid", 128'(out_valid_o), 128'h0);
        check_eq("mid_rst_empty",     128'(empty_o),     128'h1);
        check_eq("mid_rst_out_data",  out_data_o,        128'h0);
        tick();
        rst_ni = 1'b1;
        tick();
        check_eq("post_rst_empty", 128'(empty_o), 128'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
